// File: rtl/load_writeback_unit.sv
// Load/writeback stage: word read from L1, byte/half/word extract + extend, one-cycle RF write (optional LOAD_TIMEOUT_EN aborts a stuck REQ).
// Latency >= 3 cycles per load (accept, REQ until ack, WB); stall held while busy, ld_valid outside IDLE is ignored.
module load_writeback_unit #(
    parameter int n       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_addr,
    input  logic [2:0]   ld_funct3,
    input  logic [4:0]   ld_rd,
    output logic         ld_ready,
    output logic         stall,
    output logic         mem_req,
    output logic [n-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata,
    output logic [2:0]   write_sel,
    output logic [4:0]   wb_rd,
    output logic [n-1:0] ext_data,
    output logic         err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

    state_t       r_state;
    logic [1:0]   r_off;
    logic [2:0]   r_funct3;
    logic [4:0]   r_rd;
    logic         r_ld_ready;
    logic         r_stall;
    logic         r_mem_req;
    logic [n-1:0] r_mem_addr;
    logic [2:0]   r_write_sel;
    logic [4:0]   r_wb_rd;
    logic [n-1:0] r_ext_data;
    logic         r_err;

    logic         w_bad;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [n-1:0] w_ext;

`ifdef LOAD_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // Rejected before any cache traffic: illegal encodings and misaligned halves/words.
    always_comb begin
        w_bad = 1'b0;
        case (ld_funct3)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = ld_addr[0];
            3'b010:         w_bad = (ld_addr[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
    end

    assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = mem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{(n-8){w_byte[7]}}, w_byte};
            3'b100:  w_ext = {{(n-8){1'b0}}, w_byte};
            3'b001:  w_ext = {{(n-16){w_half[15]}}, w_half};
            3'b101:  w_ext = {{(n-16){1'b0}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state     <= S_IDLE;
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_ld_ready  <= 1'b1;
            r_stall     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_write_sel <= 3'b000;
            r_wb_rd     <= 5'd0;
            r_ext_data  <= '0;
            r_err       <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_err       <= 1'b0;
            r_write_sel <= 3'b000;
            r_wb_rd     <= 5'd0;
            r_ext_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (ld_valid) begin
                        r_off    <= ld_addr[1:0];
                        r_funct3 <= ld_funct3;
                        r_rd     <= ld_rd;
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {ld_addr[n-1:2], 2'b00};
                            r_ld_ready <= 1'b0;
                            r_stall    <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
                            r_cnt      <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state     <= S_WB;
                        r_mem_req   <= 1'b0;
                        r_write_sel <= (r_rd != 5'd0) ? 3'b100 : 3'b000;
                        r_wb_rd     <= r_rd;
                        r_ext_data  <= w_ext;
`ifdef LOAD_TIMEOUT_EN
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // This cycle's miss brings the count to TIMEOUT: abandon the request.
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_err      <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_stall    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_WB: begin
                    r_state    <= S_IDLE;
                    r_stall    <= 1'b0;
                    r_ld_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_stall    <= 1'b0;
                    r_mem_req  <= 1'b0;
                    r_ld_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready  = r_ld_ready;
    assign stall     = r_stall;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign write_sel = r_write_sel;
    assign wb_rd     = r_wb_rd;
    assign ext_data  = r_ext_data;
    assign err       = r_err;

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Multicycle load/writeback stage that feeds the register file's external write port.
- Accepts a load from execute and issues a word request to the L1 data cache / coherence controller.
- Waits on the cache handshake, extracts and extends the byte, half or word.
- Drives the external-input write (write_sel = 3'b100) for exactly one cycle; stalls the pipeline while busy.

Parameters:
- n, 32, data/address width
- TIMEOUT, 255, max REQ cycles before abort; used only with LOAD_TIMEOUT_EN

Ports:
- clk  input  1  system clock, all state on posedge
- n_reset  input  1  synchronous active-low reset
- ld_valid  input  1  load request from execute
- ld_addr  input  n  byte address
- ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_rd  input  5  destination register
- ld_ready  output  1  unit can accept a load this cycle
- stall  output  1  pipeline hold
- mem_req  output  1  cache read request
- mem_addr  output  n  word-aligned address {ld_addr[n-1:2],2'b00}
- mem_ack  input  1  cache data valid
- mem_rdata  input  n  cache read word
- write_sel  output  3  register-file write select, 3'b100 during writeback else 3'b000
- wb_rd  output  5  register-file rd
- ext_data  output  n  register-file external_input
- err  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout

Behaviour:
- Reset: sampled at posedge when n_reset = 0, overriding everything including a mid-transaction REQ. State goes to IDLE and all outputs are 0 except ld_ready = 1. No writeback is issued for an aborted load.
- States: IDLE, REQ, WB.
- IDLE:
  - ld_ready = 1, stall = 0, mem_req = 0.
  - On ld_valid, latch ld_addr, ld_funct3 and ld_rd.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0] = 1, or LW with addr[1:0] != 0: err = 1 next cycle, stay IDLE, no request.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1 and mem_addr held stable; ld_ready = 0, stall = 1.
  - mem_ack sampled every REQ cycle, including the first.
  - On ack, capture mem_rdata and go to WB.
- Extraction:
  - LB/LBU select byte addr[1:0], i.e. bits [8*k+7:8*k].
  - LH/LHU select half addr[1], i.e. bits [16*h+15:16*h].
  - LB/LH sign-extend to n bits; LBU/LHU zero-extend; LW passes the word through.
- WB:
  - Lasts exactly one cycle: write_sel = 3'b100, wb_rd = latched rd, ext_data = extended value; stall = 1.
  - Next state is IDLE.
  - If latched rd = 0, write_sel = 3'b000 (no write), but the cycle still occurs.
- Outside WB: write_sel = 3'b000 and ext_data = 0.
- Latency: ld_valid accepted at edge 0 means REQ from cycle 1. Ack sampled at edge k means WB in cycle k+1, IDLE at k+2. Minimum 3 cycles per load (ack on the first REQ cycle).
- mem_ack in IDLE or WB is ignored.
- ld_valid while not IDLE is ignored; upstream must honour stall.
- Back-to-back loads: the next load is accepted in the IDLE cycle after WB.

Optional Feature:
- LOAD_TIMEOUT_EN defined:
  - An 8-bit-minimum counter ($clog2(TIMEOUT+1) bits) clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT without ack: deassert mem_req, pulse err, return to IDLE, no writeback.
  - An ack in the same cycle the count hits TIMEOUT wins (normal WB).
- LOAD_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; err only from misalignment or illegal funct3.

Test Plan:
- Reset:
  - Stimulus: n_reset = 0 for 2 cycles.
  - Required: ld_ready = 1; stall, mem_req, err = 0; write_sel = 000; ext_data = 0.
- LW with immediate ack:
  - Stimulus: LW addr 0x104, rd = 5, ack in the first REQ cycle with rdata 0xDEADBEEF.
  - Required: mem_addr = 0x104; WB cycle has write_sel = 100, wb_rd = 5, ext_data = 0xDEADBEEF; stall high for exactly 2 cycles.
- Byte/half extraction:
  - Stimulus: rdata 0x80F07F81 at addr base+3 and base+2.
  - Required: LB @+3 → 0xFFFFFF80; LBU @+3 → 0x00000080; LH @+2 → 0xFFFF80F0; LHU @+2 → 0x000080F0.
- Errors:
  - Stimulus: LW addr 0x102; funct3 = 011.
  - Required: each produces a 1-cycle err, mem_req never rises, no writeback.
- Slow ack, rd 0, reset mid-REQ:
  - Stimulus: ack after 7 REQ cycles with rd = 0.
  - Required: WB cycle with write_sel = 000.
  - Stimulus: separate load with n_reset low during REQ.
  - Required: IDLE next cycle, no WB even if ack arrives.
- Timeout (LOAD_TIMEOUT_EN, TIMEOUT = 4):
  - Stimulus: no ack.
  - Required: mem_req high 4 cycles, err pulse, IDLE, no write.
  - Stimulus: ack on the 4th cycle.
  - Required: normal WB.
